// File: rtl/ext_bus_bridge_pkg.sv
// Shared types and elaboration helpers for the external bus bridge.
package ext_bus_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WR, S_TURN, S_WAIT, S_RD, S_END
  } state_t;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ext_bus_shift.sv
// MSB-first shift register moving BUS_W bits per beat; parallel load or shift-in at the bottom.
module ext_bus_shift #(
  parameter int W     = 24,
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [W-1:0]     i_load_val,
  input  logic             i_shift,
  input  logic [BUS_W-1:0] i_sin,
  output logic [W-1:0]     o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)          r_q <= '0;
    else if (i_load)  r_q <= i_load_val;
    else if (i_shift) r_q <= (r_q << BUS_W) | W'(i_sin);
  end

  assign o_q = r_q;

endmodule

// File: rtl/ext_bus_bridge.sv
// External-bus master: serialises a valid/ready request into address, write-data or
// turnaround/wait/read beats on a narrow bidirectional bus with active-low chip-selects.
module ext_bus_bridge
  import ext_bus_bridge_pkg::*;
#(
  parameter int  ADDR_W      = 16,
  parameter int  DATA_W      = 8,
  parameter int  BUS_W       = 8,
  parameter int  WAIT_CYCLES = 1,
  parameter int  NUM_CS      = 2,
  localparam int CS_W        = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [CS_W-1:0]   req_cs,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic [BUS_W-1:0]  bus_in,
  output logic [BUS_W-1:0]  bus_out,
  output logic [BUS_W-1:0]  bus_oe,
  output logic              bus_ale,
  output logic              bus_we,
  output logic              bus_re,
  output logic [NUM_CS-1:0] bus_cs_n
);

  localparam int A       = ADDR_W / BUS_W;
  localparam int D       = DATA_W / BUS_W;
  localparam int CNT_MAX = max3(A, D, WAIT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SH_W    = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] A_LD = CNT_W'(A - 1);
  localparam logic [CNT_W-1:0] D_LD = CNT_W'(D - 1);
  localparam logic [CNT_W-1:0] W_LD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  if (ADDR_W % BUS_W != 0 || DATA_W % BUS_W != 0 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15 ||
      NUM_CS < 1 || NUM_CS > 8) begin : g_bad_params
    $error("ext_bus_bridge: illegal parameter combination");
  end

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_write, r_err;
  logic [CS_W-1:0]   r_cs;
  logic              r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              w_accept, w_shift_out, w_shift_in, w_done, w_drive, w_cs_act, w_cs_bad;
  logic [SH_W-1:0]   w_sh_q;
  logic [DATA_W-1:0] w_rd_q, w_rd_nxt;
  logic [BUS_W-1:0]  w_beat;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_cs_bad  = int'(req_cs) >= NUM_CS;

  // Address and write data share one register: data beats follow the address beats.
  ext_bus_shift #(.W(SH_W), .BUS_W(BUS_W)) u_out_sh (
    .clk(clk), .rst(rst), .i_load(w_accept), .i_load_val({req_addr, req_wdata}),
    .i_shift(w_shift_out), .i_sin('0), .o_q(w_sh_q)
  );

  ext_bus_shift #(.W(DATA_W), .BUS_W(BUS_W)) u_rd_sh (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_load_val('0),
    .i_shift(w_shift_in), .i_sin(bus_in), .o_q(w_rd_q)
  );

  assign w_beat   = BUS_W'(w_sh_q >> (SH_W - BUS_W));
  assign w_rd_nxt = (w_rd_q << BUS_W) | DATA_W'(bus_in);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_out = 1'b0;
    w_shift_in  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin w_state_nxt = S_ADDR; w_cnt_nxt = A_LD; end
      S_ADDR: begin
        w_shift_out = 1'b1;
        if (r_cnt != '0)  w_cnt_nxt = r_cnt - 1'b1;
        else if (r_write) begin w_state_nxt = S_WR; w_cnt_nxt = D_LD; end
        else              w_state_nxt = S_TURN;
      end
      S_WR: begin
        w_shift_out = 1'b1;
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else begin w_state_nxt = S_END; w_done = 1'b1; end
      end
      S_TURN: begin
        if (WAIT_CYCLES > 0) begin w_state_nxt = S_WAIT; w_cnt_nxt = W_LD; end
        else                 begin w_state_nxt = S_RD;   w_cnt_nxt = D_LD; end
      end
      S_WAIT: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else begin w_state_nxt = S_RD; w_cnt_nxt = D_LD; end
      end
      S_RD: begin
        w_shift_in = 1'b1;
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else begin w_state_nxt = S_END; w_done = 1'b1; end
      end
      S_END:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_cs        <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_done;
      if (w_accept) begin
        r_write <= req_write;
        r_cs    <= req_cs;
        r_err   <= w_cs_bad;
      end
      // Read data is captured together with the final sample so it is valid with rsp_valid.
      if (w_done) begin
        r_rsp_err <= r_err;
        if (!r_write) r_rsp_rdata <= w_rd_nxt;
      end
    end
  end

  assign w_drive  = (r_state == S_ADDR) || (r_state == S_WR);
  assign w_cs_act = !r_err && (r_state inside {S_ADDR, S_WR, S_TURN, S_WAIT, S_RD});
  assign bus_oe   = {BUS_W{w_drive}};
  assign bus_out  = w_drive ? w_beat : '0;
  assign bus_ale  = (r_state == S_ADDR);
  assign bus_we   = (r_state == S_WR);
  assign bus_re   = (r_state == S_TURN) || (r_state == S_WAIT) || (r_state == S_RD);

  always_comb begin
    bus_cs_n = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (w_cs_act && int'(r_cs) == i) bus_cs_n[i] = 1'b0;
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Scoreboard bench: default bridge plus a 16-bit-data / 3-wait-state / 3-chip-select variant.
module tb_ext_bus_bridge;

  localparam int P_ADDR = 1, P_WR = 2, P_TURN = 3, P_WAIT = 4, P_RD = 5, P_END = 6;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  exp_t q1[$], q2[$];
  logic [7:0] last_rd1;

  // default instance
  logic        req_valid1, req_ready1, req_write1, rsp_valid1, rsp_err1;
  logic [15:0] req_addr1;
  logic [7:0]  req_wdata1, rsp_rdata1, bus_in1, bus_out1, bus_oe1;
  logic [0:0]  req_cs1;
  logic        bus_ale1, bus_we1, bus_re1;
  logic [1:0]  bus_cs_n1;

  // wide-data instance
  logic        req_valid2, req_ready2, req_write2, rsp_valid2, rsp_err2;
  logic [15:0] req_addr2, req_wdata2, rsp_rdata2;
  logic [7:0]  bus_in2, bus_out2, bus_oe2;
  logic [1:0]  req_cs2;
  logic        bus_ale2, bus_we2, bus_re2;
  logic [2:0]  bus_cs_n2;

  ext_bus_bridge u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_cs(req_cs1), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .bus_in(bus_in1), .bus_out(bus_out1),
    .bus_oe(bus_oe1), .bus_ale(bus_ale1), .bus_we(bus_we1), .bus_re(bus_re1), .bus_cs_n(bus_cs_n1)
  );

  ext_bus_bridge #(.ADDR_W(16), .DATA_W(16), .BUS_W(8), .WAIT_CYCLES(3), .NUM_CS(3)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .req_cs(req_cs2), .rsp_valid(rsp_valid2),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .bus_in(bus_in2), .bus_out(bus_out2),
    .bus_oe(bus_oe2), .bus_ale(bus_ale2), .bus_we(bus_we2), .bus_re(bus_re2), .bus_cs_n(bus_cs_n2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus phase of cycle k after accept, address always two beats.
  function automatic int phase(input bit wr, input int k, input int w, input int d);
    if (k <= 2) return P_ADDR;
    if (wr) return (k <= 2 + d) ? P_WR : P_END;
    if (k == 3) return P_TURN;
    if (k <= 3 + w) return P_WAIT;
    if (k <= 3 + w + d) return P_RD;
    return P_END;
  endfunction

  task automatic txn1(input bit wr, input logic [15:0] a, input logic [7:0] wd, input logic [0:0] cs,
                      input logic [7:0] rdv, input bit hold);
    int lat, t, ph;
    exp_t e;
    logic [21:0] got, exp;
    logic [7:0] eo;
    logic [1:0] ecs;
    lat = wr ? 4 : 6;
    @(negedge clk);
    req_valid1 = 1'b1; req_write1 = wr; req_addr1 = a; req_wdata1 = wd; req_cs1 = cs; bus_in1 = ~rdv;
    t = 0;
    while (!req_ready1 && t < 20) begin @(negedge clk); t++; end
    chk("idle1", {bus_oe1, bus_ale1, bus_we1, bus_re1, bus_cs_n1, req_ready1}, {8'h00, 3'b000, 2'b11, 1'b1});
    if (!req_ready1) begin req_valid1 = 1'b0; return; end
    e.rdata = wr ? {8'h00, last_rd1} : {8'h00, rdv};
    if (!wr) last_rd1 = rdv;
    e.err = 1'b0;
    e.due = cyc + lat;
    q1.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!hold) req_valid1 = 1'b0;
        req_addr1 = ~a; req_wdata1 = ~wd; req_cs1 = ~cs; req_write1 = ~wr;
      end
      ph = phase(wr, k, 1, 1);
      bus_in1 = (ph == P_RD) ? rdv : ~rdv;
      eo  = (ph == P_ADDR) ? ((k == 1) ? a[15:8] : a[7:0]) : (ph == P_WR) ? wd : 8'h00;
      ecs = (ph != P_END) ? ~(2'b01 << cs) : 2'b11;
      exp = {((ph == P_ADDR || ph == P_WR) ? 8'hFF : 8'h00), eo, ph == P_ADDR, ph == P_WR,
             (ph == P_TURN || ph == P_WAIT || ph == P_RD), ecs, 1'b0};
      got = {bus_oe1, (bus_oe1[0] ? bus_out1 : 8'h00), bus_ale1, bus_we1, bus_re1, bus_cs_n1, req_ready1};
      chk("bus1", got, exp);
    end
  endtask

  task automatic txn2(input logic [15:0] a, input logic [1:0] cs, input logic [15:0] rdv);
    int ph, t;
    exp_t e;
    logic [22:0] got, exp;
    logic [7:0] eo;
    logic [2:0] ecs;
    @(negedge clk);
    req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = a; req_wdata2 = 16'hFFFF; req_cs2 = cs;
    bus_in2 = ~rdv[7:0];
    t = 0;
    while (!req_ready2 && t < 20) begin @(negedge clk); t++; end
    chk("idle2", {bus_oe2, bus_re2, bus_cs_n2, req_ready2}, {8'h00, 1'b0, 3'b111, 1'b1});
    if (!req_ready2) begin req_valid2 = 1'b0; return; end
    e.rdata = rdv;
    e.err = (cs >= 2'd3);
    e.due = cyc + 9;
    q2.push_back(e);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      req_valid2 = 1'b0;
      ph = phase(1'b0, k, 3, 2);
      bus_in2 = (ph == P_RD) ? ((k == 7) ? rdv[15:8] : rdv[7:0]) : ~rdv[7:0];
      eo  = (ph == P_ADDR) ? ((k == 1) ? a[15:8] : a[7:0]) : 8'h00;
      ecs = (ph != P_END && cs < 2'd3) ? ~(3'b001 << cs) : 3'b111;
      exp = {((ph == P_ADDR) ? 8'hFF : 8'h00), eo, ph == P_ADDR, 1'b0,
             (ph == P_TURN || ph == P_WAIT || ph == P_RD), ecs, 1'b0};
      got = {bus_oe2, (bus_oe2[0] ? bus_out2 : 8'h00), bus_ale2, bus_we2, bus_re2, bus_cs_n2, req_ready2};
      chk("bus2", got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid1) begin
      if (q1.size() == 0) chk("rsp1_spurious", 1, 0);
      else begin
        e = q1.pop_front();
        chk("rdata1", rsp_rdata1, e.rdata[7:0]);
        chk("err1", rsp_err1, e.err);
        chk("lat1", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid2) begin
      if (q2.size() == 0) chk("rsp2_spurious", 1, 0);
      else begin
        e = q2.pop_front();
        chk("rdata2", rsp_rdata2, e.rdata);
        chk("err2", rsp_err2, e.err);
        chk("lat2", cyc, e.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; last_rd1 = 8'h00;
    req_valid1 = 0; req_write1 = 0; req_addr1 = '0; req_wdata1 = '0; req_cs1 = '0; bus_in1 = '0;
    req_valid2 = 0; req_write2 = 0; req_addr2 = '0; req_wdata2 = '0; req_cs2 = '0; bus_in2 = '0;
    repeat (3) @(negedge clk);
    chk("rst1", {rsp_valid1, rsp_rdata1, rsp_err1, bus_oe1, bus_out1, bus_ale1, bus_we1, bus_re1, bus_cs_n1, req_ready1},
        {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3'b000, 2'b11, 1'b1});
    chk("rst2", {rsp_valid2, rsp_rdata2, rsp_err2, bus_oe2, bus_re2, bus_cs_n2, req_ready2},
        {1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1});
    rst = 1'b0;

    txn1(1'b1, 16'hBEEF, 8'h5A, 1'b1, 8'h00, 1'b0);
    txn1(1'b0, 16'h1234, 8'h00, 1'b0, 8'hC3, 1'b0);
    txn1(1'b1, 16'h0081, 8'hA5, 1'b0, 8'h00, 1'b0);
    txn1(1'b0, 16'hFF00, 8'h00, 1'b1, 8'h3C, 1'b0);

    // request held high across three back-to-back writes
    txn1(1'b1, 16'h1111, 8'h01, 1'b0, 8'h00, 1'b1);
    txn1(1'b1, 16'h2222, 8'h02, 1'b1, 8'h00, 1'b1);
    txn1(1'b1, 16'h3333, 8'h03, 1'b0, 8'h00, 1'b0);

    // reset in the middle of a read's wait state
    @(negedge clk);
    req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 16'h0F0F; req_cs1 = 1'b1;
    chk("t5_ready", req_ready1, 1'b1);
    repeat (4) begin @(negedge clk); req_valid1 = 1'b0; end
    chk("t5_wait", {bus_re1, bus_oe1[0], bus_cs_n1}, {1'b1, 1'b0, 2'b01});
    rst = 1'b1;
    @(negedge clk);
    chk("t5_abort", {bus_oe1, bus_re1, bus_cs_n1, req_ready1, rsp_valid1}, {8'h00, 1'b0, 2'b11, 1'b1, 1'b0});
    rst = 1'b0; last_rd1 = 8'h00; seen = 0;
    repeat (12) begin @(negedge clk); if (rsp_valid1) seen++; end
    chk("t5_norsp", seen, 0);
    chk("t5_rdata", rsp_rdata1, 8'h00);
    txn1(1'b1, 16'h4444, 8'h44, 1'b1, 8'h00, 1'b0);

    // wide data, three wait states, out-of-range chip-select
    txn2(16'h4321, 2'd2, 16'hABCD);
    txn2(16'h8001, 2'd3, 16'h5AA5);
    txn2(16'h00FE, 2'd0, 16'h0F1E);

    repeat (4) @(negedge clk);
    chk("q1_drain", q1.size(), 0);
    chk("q2_drain", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
